// File: rtl/write_data_buffer_responder_pkg.sv
// Shared types and constants for the buffer-read responder: request and staging
// line layouts, the per-beat error flags and the doubleword parity helper.
package write_data_buffer_responder_pkg;

    localparam int CACHELINE_SIZE_BITS_HF = 512;
    localparam int NUM_TAGS_DEFAULT       = 32;
    localparam int BRLAT_DEFAULT          = 1;

    // PSL buffer-read request; read_address[5] selects the 64-byte half.
    typedef struct packed {
        logic       read_valid;
        logic [7:0] read_tag;
        logic       read_tag_parity;
        logic [5:0] read_address;
    } WriteDataControlInterface;

    typedef struct packed {
        logic [7:0] tag;
    } WriteDataCommand;

    // One staged half-line from the compute-unit write-data path.
    typedef struct packed {
        logic                              valid;
        WriteDataCommand                   cmd;
        logic [CACHELINE_SIZE_BITS_HF-1:0] data;
    } ReadWriteDataLine;

    // Bit 0 = tag_parity, bit 1 = unstaged, bit 2 = out_of_range.
    typedef struct packed {
        logic out_of_range;
        logic unstaged;
        logic tag_parity;
    } WriteDataResponderError;

    // One beat travelling down the read pipeline.
    typedef struct packed {
        logic                              valid;
        logic [CACHELINE_SIZE_BITS_HF-1:0] data;
        WriteDataResponderError            err;
    } ResponseBeat;

    function automatic logic odd_parity_64(input logic [63:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/write_data_buffer_responder_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same address on one edge returns the old contents.
module write_data_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port and registered read port; non-blocking update gives read-before-write.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/write_data_buffer_responder.sv
// AFU-side responder for PSL buffer-read requests. Stages outbound write
// half-lines per command tag and returns the requested half, with odd parity
// per doubleword and per-beat error flags, BRLAT cycles after the request.
//
// Handshake: there is no backpressure. A request is taken in every cycle where
// read_valid and enabled_in are both high; exactly one beat with
// write_data_valid_out high comes out BRLAT cycles later.
import write_data_buffer_responder_pkg::*;

module write_data_buffer_responder #(
    parameter int NUM_TAGS = NUM_TAGS_DEFAULT,
    parameter int BRLAT    = BRLAT_DEFAULT
) (
    input  logic                              clock,
    input  logic                              rstn,
    input  logic                              enabled_in,
    input  WriteDataControlInterface          wdata_ctrl_in,
    input  ReadWriteDataLine                  write_data_0_in,
    input  ReadWriteDataLine                  write_data_1_in,
    input  logic                              free_tag_valid_in,
    input  logic [7:0]                        free_tag_in,
    output logic [CACHELINE_SIZE_BITS_HF-1:0] write_data_out,
    output logic [7:0]                        write_parity_out,
    output logic                              write_data_valid_out,
    output logic [NUM_TAGS-1:0]               tag_ready_out,
    output logic [2:0]                        data_error_out
);

    localparam int IDXW = $clog2(NUM_TAGS);
    localparam int W    = CACHELINE_SIZE_BITS_HF;

    // A tag addresses the entry table only if the bits above the index are zero.
    function automatic logic tag_in_range(input logic [7:0] tag);
        return (tag >> IDXW) == 8'd0;
    endfunction

    // ---------------- staging / free ----------------
    logic [NUM_TAGS-1:0] half0_q, half0_d;
    logic [NUM_TAGS-1:0] half1_q, half1_d;
    logic [NUM_TAGS-1:0] ready_q;

    logic [IDXW-1:0] st0_idx, st1_idx, free_idx;
    logic            st0_we, st1_we, free_en;

    assign st0_idx  = write_data_0_in.cmd.tag[IDXW-1:0];
    assign st1_idx  = write_data_1_in.cmd.tag[IDXW-1:0];
    assign free_idx = free_tag_in[IDXW-1:0];
    assign st0_we   = enabled_in & write_data_0_in.valid & tag_in_range(write_data_0_in.cmd.tag);
    assign st1_we   = enabled_in & write_data_1_in.valid & tag_in_range(write_data_1_in.cmd.tag);
    assign free_en  = enabled_in & free_tag_valid_in & tag_in_range(free_tag_in);

    // Next half-valid bitmaps: a free clears first, a same-cycle stage then sets its half.
    always_comb begin
        half0_d = half0_q;
        half1_d = half1_q;
        if (free_en) begin
            half0_d[free_idx] = 1'b0;
            half1_d[free_idx] = 1'b0;
        end
        if (st0_we) begin
            half0_d[st0_idx] = 1'b1;
        end
        if (st1_we) begin
            half1_d[st1_idx] = 1'b1;
        end
    end

    // Half-valid state; ready follows one cycle after both halves are present.
    always_ff @(posedge clock) begin
        if (!rstn) begin
            half0_q <= '0;
            half1_q <= '0;
            ready_q <= '0;
        end else begin
            half0_q <= half0_d;
            half1_q <= half1_d;
            ready_q <= half0_q & half1_q;
        end
    end

    // ---------------- read request decode ----------------
    logic [IDXW-1:0]        rd_idx;
    logic                   rd_fire, rd_in_range, rd_half, rd_staged;
    WriteDataResponderError rd_err;
    logic                   unused_addr_bits;

    assign rd_idx      = wdata_ctrl_in.read_tag[IDXW-1:0];
    assign rd_fire     = enabled_in & wdata_ctrl_in.read_valid;
    assign rd_in_range = tag_in_range(wdata_ctrl_in.read_tag);
    assign rd_half     = wdata_ctrl_in.read_address[5];
    // Only the half-select bit matters; the low address bits are don't-care.
    assign unused_addr_bits = ^wdata_ctrl_in.read_address[4:0];
    // Staged state is looked up before this edge's stage/free take effect.
    assign rd_staged   = rd_half ? half1_q[rd_idx] : half0_q[rd_idx];

    // Error flags for the incoming request; an out-of-range tag reports only that.
    always_comb begin
        rd_err              = '0;
        rd_err.tag_parity   = wdata_ctrl_in.read_tag_parity != ~^wdata_ctrl_in.read_tag;
        rd_err.out_of_range = ~rd_in_range;
        rd_err.unstaged     = rd_in_range & ~rd_staged;
    end

    // ---------------- RAMs (one per half) ----------------
    logic [W-1:0] ram0_rdata, ram1_rdata;

    write_data_ram #(.DEPTH(NUM_TAGS), .WIDTH(W)) u_ram_half0 (
        .clock   (clock),
        .we_i    (st0_we),
        .waddr_i (st0_idx),
        .wdata_i (write_data_0_in.data),
        .re_i    (rd_fire & rd_in_range),
        .raddr_i (rd_idx),
        .rdata_o (ram0_rdata)
    );

    write_data_ram #(.DEPTH(NUM_TAGS), .WIDTH(W)) u_ram_half1 (
        .clock   (clock),
        .we_i    (st1_we),
        .waddr_i (st1_idx),
        .wdata_i (write_data_1_in.data),
        .re_i    (rd_fire & rd_in_range),
        .raddr_i (rd_idx),
        .rdata_o (ram1_rdata)
    );

    // ---------------- read pipeline ----------------
    logic                   s1_valid_q;
    logic                   s1_half_q;
    WriteDataResponderError s1_err_q;
    ResponseBeat            s1_beat;
    ResponseBeat            pipe_q [BRLAT];

    // Control that travels alongside the registered RAM read.
    always_ff @(posedge clock) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_half_q  <= 1'b0;
            s1_err_q   <= '0;
        end else begin
            s1_valid_q <= rd_fire;
            s1_half_q  <= rd_half;
            s1_err_q   <= rd_fire ? rd_err : '0;
        end
    end

    // Select the requested half; unstaged or out-of-range beats carry zero data.
    always_comb begin
        s1_beat       = '0;
        s1_beat.valid = s1_valid_q;
        s1_beat.err   = s1_err_q;
        if (s1_valid_q && !s1_err_q.unstaged && !s1_err_q.out_of_range) begin
            s1_beat.data = s1_half_q ? ram1_rdata : ram0_rdata;
        end
    end

    // BRLAT beat registers; reset flushes anything in flight.
    always_ff @(posedge clock) begin
        if (!rstn) begin
            for (int k = 0; k < BRLAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= s1_beat;
            for (int k = 1; k < BRLAT; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    // Drive the last stage; parity is generated here over the data actually driven.
    always_comb begin
        write_data_out       = '0;
        write_parity_out     = '0;
        write_data_valid_out = 1'b0;
        data_error_out       = '0;
        tag_ready_out        = '0;
        if (enabled_in) begin
            tag_ready_out = ready_q;
            if (pipe_q[BRLAT-1].valid) begin
                write_data_out       = pipe_q[BRLAT-1].data;
                write_data_valid_out = 1'b1;
                data_error_out       = pipe_q[BRLAT-1].err;
                for (int i = 0; i < 8; i++) begin
                    write_parity_out[i] = odd_parity_64(pipe_q[BRLAT-1].data[64*i +: 64]);
                end
            end
        end
    end

endmodule

// File: tb/tb_write_data_buffer_responder.sv
// Directed bench for write_data_buffer_responder. Two instances (BRLAT=1 and
// BRLAT=3) see identical stimulus; a negedge monitor compares every cycle of
// each against an expected-beat queue.
import write_data_buffer_responder_pkg::*;

module tb_write_data_buffer_responder;

    localparam int W = CACHELINE_SIZE_BITS_HF;

    localparam logic [W-1:0] D_AA   = {64{8'hAA}};
    localparam logic [W-1:0] D_55   = {64{8'h55}};
    localparam logic [W-1:0] D_11   = {64{8'h11}};
    localparam logic [W-1:0] D_22   = {64{8'h22}};
    localparam logic [W-1:0] D_33   = {64{8'h33}};
    localparam logic [W-1:0] D_BIT0 = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] D_DW1  = {8{64'h0000_0000_0000_0001}};

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic rstn = 1'b0;
    logic enabled_in = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    WriteDataControlInterface ctrl;
    ReadWriteDataLine         wd0, wd1;
    logic                     free_v;
    logic [7:0]               free_tag;

    logic [W-1:0] d1_data, d3_data;
    logic [7:0]   d1_par, d3_par;
    logic         d1_valid, d3_valid;
    logic [31:0]  d1_ready, d3_ready;
    logic [2:0]   d1_err, d3_err;

    write_data_buffer_responder #(.NUM_TAGS(32), .BRLAT(1)) dut_l1 (
        .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .wdata_ctrl_in(ctrl),
        .write_data_0_in(wd0), .write_data_1_in(wd1),
        .free_tag_valid_in(free_v), .free_tag_in(free_tag),
        .write_data_out(d1_data), .write_parity_out(d1_par), .write_data_valid_out(d1_valid),
        .tag_ready_out(d1_ready), .data_error_out(d1_err)
    );

    write_data_buffer_responder #(.NUM_TAGS(32), .BRLAT(3)) dut_l3 (
        .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .wdata_ctrl_in(ctrl),
        .write_data_0_in(wd0), .write_data_1_in(wd1),
        .free_tag_valid_in(free_v), .free_tag_in(free_tag),
        .write_data_out(d3_data), .write_parity_out(d3_par), .write_data_valid_out(d3_valid),
        .tag_ready_out(d3_ready), .data_error_out(d3_err)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        int           due;
        logic [W-1:0] data;
        logic [7:0]   par;
        logic [2:0]   err;
    } exp_t;

    exp_t exp_q1[$];
    exp_t exp_q3[$];
    exp_t mon_e1, mon_e3;

    // Each cycle a DUT either presents the beat due now or must be idle.
    always @(negedge clock) begin
        if (exp_q1.size() > 0 && exp_q1[0].due == cyc) begin
            mon_e1 = exp_q1.pop_front();
            check("l1_valid", W'(d1_valid), W'(1'b1));
            check("l1_data", d1_data, mon_e1.data);
            check("l1_par", W'(d1_par), W'(mon_e1.par));
            check("l1_err", W'(d1_err), W'(mon_e1.err));
        end else begin
            check("l1_idle", W'(d1_valid), W'(1'b0));
        end
        if (exp_q3.size() > 0 && exp_q3[0].due == cyc) begin
            mon_e3 = exp_q3.pop_front();
            check("l3_valid", W'(d3_valid), W'(1'b1));
            check("l3_data", d3_data, mon_e3.data);
            check("l3_par", W'(d3_par), W'(mon_e3.par));
            check("l3_err", W'(d3_err), W'(mon_e3.err));
        end else begin
            check("l3_idle", W'(d3_valid), W'(1'b0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        ctrl     = '0;
        wd0      = '0;
        wd1      = '0;
        free_v   = 1'b0;
        free_tag = 8'd0;
    endtask

    task automatic set_read(input logic [7:0] tag, input logic [5:0] addr, input logic bad_par);
        ctrl.read_valid      = 1'b1;
        ctrl.read_tag        = tag;
        ctrl.read_tag_parity = (~^tag) ^ bad_par;
        ctrl.read_address    = addr;
    endtask

    // Request sampled at the next edge N; beat due after edge N+BRLAT.
    task automatic expect_beat(input logic [W-1:0] data, input logic [7:0] par, input logic [2:0] err);
        exp_t e;
        e.data = data;
        e.par  = par;
        e.err  = err;
        e.due  = cyc + 1 + 1;
        exp_q1.push_back(e);
        e.due  = cyc + 1 + 3;
        exp_q3.push_back(e);
    endtask

    task automatic read_beat(input logic [7:0] tag, input logic [5:0] addr, input logic bad_par,
                             input logic [W-1:0] data, input logic [7:0] par, input logic [2:0] err);
        set_read(tag, addr, bad_par);
        expect_beat(data, par, err);
        step();
        ctrl = '0;
    endtask

    task automatic drain();
        repeat (5) step();
    endtask

    task automatic check_ready(input string tag, input int idx, input logic exp);
        check({tag, "_l1"}, W'(d1_ready[idx]), W'(exp));
        check({tag, "_l3"}, W'(d3_ready[idx]), W'(exp));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        clear_inputs();
        rstn       = 1'b0;
        enabled_in = 1'b1;
        repeat (3) step();
        check("rst_data_l1", d1_data, '0);
        check("rst_data_l3", d3_data, '0);
        check("rst_ctl_l1", W'({d1_valid, d1_par, d1_err, d1_ready}), '0);
        check("rst_ctl_l3", W'({d3_valid, d3_par, d3_err, d3_ready}), '0);
        rstn = 1'b1;
        step();

        // Stage both halves of tag 5 in one cycle; ready rises one cycle later.
        wd0.valid = 1'b1; wd0.cmd.tag = 8'd5; wd0.data = D_AA;
        wd1.valid = 1'b1; wd1.cmd.tag = 8'd5; wd1.data = D_55;
        step();
        clear_inputs();
        check_ready("t1_ready_early", 5, 1'b0);
        step();
        check_ready("t1_ready", 5, 1'b1);
        read_beat(8'd5, 6'h00, 1'b0, D_AA, 8'hFF, 3'b000);
        drain();

        // Back-to-back reads with no bubbles.
        read_beat(8'd5, 6'h20, 1'b0, D_55, 8'hFF, 3'b000);
        read_beat(8'd5, 6'h00, 1'b0, D_AA, 8'hFF, 3'b000);
        read_beat(8'd5, 6'h3F, 1'b0, D_55, 8'hFF, 3'b000);
        drain();

        // Bad tag parity still returns data.
        read_beat(8'd5, 6'h1F, 1'b1, D_AA, 8'hFF, 3'b001);
        // Unstaged half, then out-of-range tag.
        read_beat(8'd7, 6'h20, 1'b0, '0, 8'hFF, 3'b010);
        read_beat(8'h80, 6'h00, 1'b0, '0, 8'hFF, 3'b100);
        drain();

        // Parity bit ordering: doubleword 0 odd count in half 0; every doubleword in half 1.
        wd0.valid = 1'b1; wd0.cmd.tag = 8'd3; wd0.data = D_BIT0;
        wd1.valid = 1'b1; wd1.cmd.tag = 8'd3; wd1.data = D_DW1;
        step();
        clear_inputs();
        read_beat(8'd3, 6'h00, 1'b0, D_BIT0, 8'hFE, 3'b000);
        read_beat(8'd3, 6'h20, 1'b0, D_DW1, 8'h00, 3'b000);
        drain();

        // Free and re-stage half 0 of tag 5 in the same cycle.
        free_v = 1'b1; free_tag = 8'd5;
        wd0.valid = 1'b1; wd0.cmd.tag = 8'd5; wd0.data = D_11;
        step();
        clear_inputs();
        step();
        check_ready("t5_ready_freed", 5, 1'b0);
        read_beat(8'd5, 6'h00, 1'b0, D_11, 8'hFF, 3'b000);
        read_beat(8'd5, 6'h20, 1'b0, '0, 8'hFF, 3'b010);
        wd1.valid = 1'b1; wd1.cmd.tag = 8'd5; wd1.data = D_22;
        step();
        clear_inputs();
        step();
        check_ready("t5_ready_again", 5, 1'b1);
        read_beat(8'd5, 6'h00, 1'b0, D_11, 8'hFF, 3'b000);
        read_beat(8'd5, 6'h20, 1'b0, D_22, 8'hFF, 3'b000);
        drain();

        // Read and stage of the same half in one cycle returns the old contents.
        wd0.valid = 1'b1; wd0.cmd.tag = 8'd5; wd0.data = D_33;
        read_beat(8'd5, 6'h00, 1'b0, D_11, 8'hFF, 3'b000);
        clear_inputs();
        read_beat(8'd5, 6'h00, 1'b0, D_33, 8'hFF, 3'b000);
        drain();

        // Disabled: requests and staging are ignored, outputs stay at reset values.
        enabled_in = 1'b0;
        set_read(8'd5, 6'h00, 1'b0);
        wd0.valid = 1'b1; wd0.cmd.tag = 8'd9; wd0.data = D_AA;
        step();
        clear_inputs();
        check_ready("dis_ready_masked", 5, 1'b0);
        drain();
        enabled_in = 1'b1;
        step();
        read_beat(8'd9, 6'h00, 1'b0, '0, 8'hFF, 3'b010);
        drain();

        // Reset lands one edge after a read is sampled: the beat never appears.
        set_read(8'd5, 6'h00, 1'b0);
        step();
        ctrl = '0;
        rstn = 1'b0;
        step();
        step();
        check_ready("rst_mid_ready", 5, 1'b0);
        rstn = 1'b1;
        step();
        read_beat(8'd5, 6'h00, 1'b0, '0, 8'hFF, 3'b010);
        drain();

        check("q1_empty", W'(exp_q1.size()), '0);
        check("q3_empty", W'(exp_q3.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
